operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Decode-to-execute operand stage directly downstream of the 16-entry register file.
//  Drives the file's two read addresses, resolves RAW hazards by forwarding, and registers operands plus control.
//  Presents them to execute through a valid/ready handshake with a 2-entry skid buffer (main + skid).
//  Address 15 reads the R15 (PC+8) value supplied to the register file and is never forwarded.
// PARAMETERS
//  W   32  data width; matches register-file W
//  CW  16  width of opaque decoded-control word carried alongside operands
// PORTS
//  CLK          in   1   single clock, rising edge
//  RESET        in   1   asynchronous, active-high reset
//  FLUSH        in   1   synchronous kill of all held entries (branch taken)
//  IN_VALID     in   1   decode presents an instruction
//  IN_READY     out  1   stage can accept; equals !skid_valid (registered)
//  RA1, RA2     in   4   source register numbers from decode
//  IN_CTRL      in   CW  decoded control word
//  AD1, AD2     out  4   register-file read addresses; combinational copy of RA1/RA2
//  DO1, DO2     in   W   register-file read data
//  FWD_EX_EN    in   1   execute result will be written back
//  FWD_EX_AD    in   4   execute destination register
//  FWD_EX_DATA  in   W   execute result
//  FWD_WB_EN    in   1   writeback this cycle (same as register-file WE)
//  FWD_WB_AD    in   4   writeback address (register-file WAD)
//  FWD_WB_DATA  in   W   writeback data (register-file WDI)
//  OUT_VALID    out  1   OP1/OP2/OUT_CTRL valid for execute
//  OUT_READY    in   1   execute consumes this cycle
//  OP1, OP2     out  W   resolved operands
//  OUT_AD1/2    out  4   source numbers of held operands
//  OUT_CTRL     out  CW  control word of held instruction
// BEHAVIOUR
//  - Reset (async): main/skid valid=0, all data/ctrl/address regs=0; OUT_VALID=0, IN_READY=1.
//  - Operand resolve, per port i: if RAi==15 -> DOi.
//    Else if FWD_EX_EN && FWD_EX_AD==RAi -> FWD_EX_DATA.
//    Else if FWD_WB_EN && FWD_WB_AD==RAi -> FWD_WB_DATA.
//    Else -> DOi. EX has priority over WB.
//  - accept = IN_VALID & IN_READY; take = OUT_VALID & OUT_READY.
//  - Latency: accepted instruction appears on OUT the next cycle if main is empty or taken that cycle.
//  - Main-empty or taken: accept writes main. Skid non-empty and taken: skid moves to main, skid clears.
//  - Main held (valid & !OUT_READY) and accept: entry written to skid; IN_READY drops next cycle.
//  - accept never occurs when skid full, so overflow is impossible by construction.
//  - Snoop: each cycle, any held entry (main or skid) whose OUT_ADi!=15 matches FWD_WB_AD with FWD_WB_EN
//    has OPi overwritten with FWD_WB_DATA; entries being moved/loaded the same edge take the snooped value.
//  - FLUSH: next edge clears main and skid valid; a same-cycle accept is discarded; take still counts
//    for execute. IN_READY=1 the cycle after. FLUSH has priority over all other updates.
//  - Simultaneous accept+take with skid empty: main loads new entry, OUT_VALID stays 1 (no bubble).
//  - OUT_* data are stable while OUT_VALID & !OUT_READY except via snoop updates.
//  - RESET mid-operation discards all entries immediately; no handshake completes that cycle.
// STRUCTURE
//  - Shared package: REG_PC = 4'd15, register-address width 4, forward-select encoding {RF,EX,WB}.
//  - Sub-module operand_forward_mux (combinational priority mux), instantiated twice (port 1, port 2).
//  - Top holds the skid-buffer control (2 valid bits) and entry registers.
// TESTING
//  - Reset: RESET=1 mid-stream -> OUT_VALID=0, IN_READY=1, OP1=OP2=0 immediately.
//  - Forward priority: RA1=3, DO1=0x11, EX(3,0x22), WB(3,0x33) -> OP1=0x22 next cycle; EX off -> 0x33.
//  - R15: RA2=15, DO2=0x108, EX(15,0xDEAD) enabled -> OP2=0x108.
//  - Backpressure: OUT_READY=0, send A,B -> A held, B in skid, IN_READY=0; C stalls.
//    OUT_READY=1 -> A,B,C leave in order, one per cycle.
//  - Snoop: A(RA1=5) held, WB(5,0x55) -> OP1 becomes 0x55 next cycle, OUT_VALID stays 1.
//  - Flush: two entries held, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, nothing accepted.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and helpers for the operand-fetch stage.
package operand_fetch_stage_pkg;
  localparam int RA_W = 4;
  localparam logic [RA_W-1:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  // Source choice for one operand; R15 always comes from the file, EX beats WB.
  function automatic fwd_sel_e fwd_select(input logic [RA_W-1:0] ra,
                                          input logic            ex_en,
                                          input logic [RA_W-1:0] ex_ad,
                                          input logic            wb_en,
                                          input logic [RA_W-1:0] wb_ad);
    if (ra == REG_PC)              return FWD_RF;
    else if (ex_en && ex_ad == ra) return FWD_EX;
    else if (wb_en && wb_ad == ra) return FWD_WB;
    else                           return FWD_RF;
  endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode / register-file / forward / execute signals of the operand-fetch stage.
interface operand_fetch_stage_if #(
  parameter int W  = 32,
  parameter int CW = 16
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ra1, ra2;
  logic [CW-1:0] in_ctrl;
  logic [3:0]    ad1, ad2;
  logic [W-1:0]  do1, do2;
  logic          fwd_ex_en;
  logic [3:0]    fwd_ex_ad;
  logic [W-1:0]  fwd_ex_data;
  logic          fwd_wb_en;
  logic [3:0]    fwd_wb_ad;
  logic [W-1:0]  fwd_wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  op1, op2;
  logic [3:0]    out_ad1, out_ad2;
  logic [CW-1:0] out_ctrl;

  modport slave (
    input  flush, in_valid, ra1, ra2, in_ctrl, do1, do2,
           fwd_ex_en, fwd_ex_ad, fwd_ex_data, fwd_wb_en, fwd_wb_ad, fwd_wb_data, out_ready,
    output in_ready, ad1, ad2, out_valid, op1, op2, out_ad1, out_ad2, out_ctrl
  );

  modport master (
    output flush, in_valid, ra1, ra2, in_ctrl, do1, do2,
           fwd_ex_en, fwd_ex_ad, fwd_ex_data, fwd_wb_en, fwd_wb_ad, fwd_wb_data, out_ready,
    input  in_ready, ad1, ad2, out_valid, op1, op2, out_ad1, out_ad2, out_ctrl
  );
endinterface

// File: rtl/operand_forward_mux.sv
// Combinational forward mux for one operand port: RF / EX / WB by priority.
module operand_forward_mux
  import operand_fetch_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [RA_W-1:0] ra_i,
  input  logic [W-1:0]    rf_data_i,
  input  logic            ex_en_i,
  input  logic [RA_W-1:0] ex_ad_i,
  input  logic [W-1:0]    ex_data_i,
  input  logic            wb_en_i,
  input  logic [RA_W-1:0] wb_ad_i,
  input  logic [W-1:0]    wb_data_i,
  output logic [W-1:0]    data_o
);
  fwd_sel_e sel;

  // Pick the youngest in-flight producer of the source register.
  always_comb begin
    sel = fwd_select(ra_i, ex_en_i, ex_ad_i, wb_en_i, wb_ad_i);
    case (sel)
      FWD_EX:  data_o = ex_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = rf_data_i;
    endcase
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: forward-resolve sources, hold them in a main+skid buffer for execute.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_fetch_stage_if.slave bus
);
  typedef struct packed {
    logic [W-1:0]    op1;
    logic [W-1:0]    op2;
    logic [RA_W-1:0] ad1;
    logic [RA_W-1:0] ad2;
    logic [CW-1:0]   ctrl;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, new_ent;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   [W-1:0] rd1, rd2;
  logic   accept, take;

  // A held entry picks up a writeback to one of its (non-PC) sources.
  function automatic entry_t snoop(input entry_t e, input logic en,
                                   input logic [RA_W-1:0] ad, input logic [W-1:0] d);
    entry_t r;
    r = e;
    if (en && e.ad1 != REG_PC && e.ad1 == ad) r.op1 = d;
    if (en && e.ad2 != REG_PC && e.ad2 == ad) r.op2 = d;
    return r;
  endfunction

  operand_forward_mux #(.W(W)) u_fwd1 (
    .ra_i(bus.ra1), .rf_data_i(bus.do1),
    .ex_en_i(bus.fwd_ex_en), .ex_ad_i(bus.fwd_ex_ad), .ex_data_i(bus.fwd_ex_data),
    .wb_en_i(bus.fwd_wb_en), .wb_ad_i(bus.fwd_wb_ad), .wb_data_i(bus.fwd_wb_data),
    .data_o(rd1)
  );

  operand_forward_mux #(.W(W)) u_fwd2 (
    .ra_i(bus.ra2), .rf_data_i(bus.do2),
    .ex_en_i(bus.fwd_ex_en), .ex_ad_i(bus.fwd_ex_ad), .ex_data_i(bus.fwd_ex_data),
    .wb_en_i(bus.fwd_wb_en), .wb_ad_i(bus.fwd_wb_ad), .wb_data_i(bus.fwd_wb_data),
    .data_o(rd2)
  );

  assign bus.ad1      = bus.ra1;
  assign bus.ad2      = bus.ra2;
  assign bus.in_ready = !skid_vld_q;
  assign bus.out_valid = main_vld_q;
  assign bus.op1      = main_q.op1;
  assign bus.op2      = main_q.op2;
  assign bus.out_ad1  = main_q.ad1;
  assign bus.out_ad2  = main_q.ad2;
  assign bus.out_ctrl = main_q.ctrl;

  assign accept  = bus.in_valid && !skid_vld_q;
  assign take    = main_vld_q && bus.out_ready;
  assign new_ent = '{op1: rd1, op2: rd2, ad1: bus.ra1, ad2: bus.ra2, ctrl: bus.in_ctrl};

  // Buffer update: flush wins; a free/draining main refills from skid first, else from decode.
  always_comb begin
    main_d     = snoop(main_q, bus.fwd_wb_en, bus.fwd_wb_ad, bus.fwd_wb_data);
    skid_d     = snoop(skid_q, bus.fwd_wb_en, bus.fwd_wb_ad, bus.fwd_wb_data);
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || take) begin
      if (skid_vld_q) begin
        main_d     = skid_d;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = new_ent;
      end
    end else if (accept) begin
      skid_d     = new_ent;
      skid_vld_d = 1'b1;
    end
  end

  // Entry and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus random traffic vs a queue model.
module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  operand_fetch_stage_if #(.W(32), .CW(16)) bus ();
  operand_fetch_stage #(.W(32), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1, op2;
    logic [3:0]  a1, a2;
    logic [15:0] ctrl;
  } ent_t;

  ent_t q[$];

  function automatic logic [31:0] resolve(input logic [3:0] ra, input logic [31:0] rf);
    if (ra == 4'd15) return rf;
    if (bus.fwd_ex_en && bus.fwd_ex_ad == ra) return bus.fwd_ex_data;
    if (bus.fwd_wb_en && bus.fwd_wb_ad == ra) return bus.fwd_wb_data;
    return rf;
  endfunction

  // Reference: an in-order queue of at most two instructions.
  always @(posedge clk or posedge rst) begin
    int   sz;
    bit   tk, ac;
    ent_t e;
    if (rst) q.delete();
    else begin
      sz = q.size();
      tk = (sz > 0) && bus.out_ready;
      ac = bus.in_valid && (sz < 2);
      e.op1  = resolve(bus.ra1, bus.do1);
      e.op2  = resolve(bus.ra2, bus.do2);
      e.a1   = bus.ra1;
      e.a2   = bus.ra2;
      e.ctrl = bus.in_ctrl;
      foreach (q[i]) begin
        if (bus.fwd_wb_en && q[i].a1 != 4'd15 && q[i].a1 == bus.fwd_wb_ad) q[i].op1 = bus.fwd_wb_data;
        if (bus.fwd_wb_en && q[i].a2 != 4'd15 && q[i].a2 == bus.fwd_wb_ad) q[i].op2 = bus.fwd_wb_data;
      end
      if (bus.flush) q.delete();
      else begin
        if (tk) void'(q.pop_front());
        if (ac) q.push_back(e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("ad1", bus.ad1, bus.ra1);
    chk("ad2", bus.ad2, bus.ra2);
    if (q.size() > 0) begin
      chk("op1", bus.op1, q[0].op1);
      chk("op2", bus.op2, q[0].op2);
      chk("out_ad1", bus.out_ad1, q[0].a1);
      chk("out_ad2", bus.out_ad2, q[0].a2);
      chk("out_ctrl", bus.out_ctrl, q[0].ctrl);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic set_idle();
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    bus.ra1 = 0; bus.ra2 = 0; bus.in_ctrl = 0; bus.do1 = 0; bus.do2 = 0;
    bus.fwd_ex_en = 0; bus.fwd_ex_ad = 0; bus.fwd_ex_data = 0;
    bus.fwd_wb_en = 0; bus.fwd_wb_ad = 0; bus.fwd_wb_data = 0;
  endtask

  task automatic send(input logic [15:0] c, input logic [3:0] a1, input logic [3:0] a2);
    bus.in_valid = 1; bus.in_ctrl = c; bus.ra1 = a1; bus.ra2 = a2;
  endtask

  function automatic logic [3:0] pick_ad();
    case ($urandom_range(0, 3))
      0:       return 4'd3;
      1:       return 4'd5;
      2:       return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    set_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_op1", bus.op1, 0);
    rst = 0;
    cyc();

    // Forward priority: EX over WB over RF.
    send(16'h0001, 4'd3, 4'd0);
    bus.do1 = 32'h11;
    bus.fwd_ex_en = 1; bus.fwd_ex_ad = 4'd3; bus.fwd_ex_data = 32'h22;
    bus.fwd_wb_en = 1; bus.fwd_wb_ad = 4'd3; bus.fwd_wb_data = 32'h33;
    cyc();
    chk("fwd_ex", bus.op1, 32'h22);
    bus.fwd_ex_en = 0;
    cyc();
    chk("fwd_wb", bus.op1, 32'h33);
    chk("fwd_wb_valid", bus.out_valid, 1);

    // R15 is never forwarded.
    set_idle();
    send(16'h0002, 4'd0, 4'd15);
    bus.do2 = 32'h108;
    bus.fwd_ex_en = 1; bus.fwd_ex_ad = 4'd15; bus.fwd_ex_data = 32'hDEAD;
    cyc();
    chk("r15_op2", bus.op2, 32'h108);
    set_idle();
    cyc();

    // Backpressure: A in main, B in skid, C stalls, then drain in order.
    bus.out_ready = 0;
    send(16'hA, 4'd1, 4'd2); cyc();
    chk("bp_a_ctrl", bus.out_ctrl, 16'hA);
    send(16'hB, 4'd1, 4'd2); cyc();
    chk("bp_b_ready", bus.in_ready, 0);
    send(16'hC, 4'd1, 4'd2); cyc();
    chk("bp_c_hold", bus.out_ctrl, 16'hA);
    bus.out_ready = 1; cyc();
    chk("bp_drain_b", bus.out_ctrl, 16'hB);
    cyc();
    chk("bp_drain_c", bus.out_ctrl, 16'hC);
    bus.in_valid = 0; cyc();
    chk("bp_empty", bus.out_valid, 0);

    // Snoop a held entry.
    bus.out_ready = 0;
    send(16'h5, 4'd5, 4'd0); bus.do1 = 32'h1; cyc();
    chk("snoop_pre", bus.op1, 32'h1);
    bus.in_valid = 0;
    bus.fwd_wb_en = 1; bus.fwd_wb_ad = 4'd5; bus.fwd_wb_data = 32'h55; cyc();
    chk("snoop_op1", bus.op1, 32'h55);
    chk("snoop_valid", bus.out_valid, 1);
    set_idle(); cyc();

    // Flush with two held entries and a pending input.
    bus.out_ready = 0;
    send(16'hD, 4'd1, 4'd2); cyc();
    send(16'hE, 4'd1, 4'd2); cyc();
    bus.flush = 1; send(16'hF, 4'd1, 4'd2); cyc();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ready", bus.in_ready, 1);
    bus.flush = 0; bus.in_valid = 0; cyc();
    chk("flush_none", bus.out_valid, 0);

    // Reset mid-stream with an entry held.
    send(16'h7, 4'd2, 4'd3); bus.do1 = 32'h77; bus.do2 = 32'h78; cyc();
    rst = 1;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_op1", bus.op1, 0);
    chk("mrst_op2", bus.op2, 0);
    cyc();
    rst = 0;
    set_idle();
    cyc();

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid    = ($urandom_range(0, 9) < 7);
      bus.out_ready   = ($urandom_range(0, 9) < 6);
      bus.flush       = ($urandom_range(0, 31) == 0);
      bus.ra1         = pick_ad();
      bus.ra2         = pick_ad();
      bus.in_ctrl     = 16'($urandom);
      bus.do1         = $urandom;
      bus.do2         = $urandom;
      bus.fwd_ex_en   = $urandom_range(0, 1);
      bus.fwd_ex_ad   = pick_ad();
      bus.fwd_ex_data = $urandom;
      bus.fwd_wb_en   = $urandom_range(0, 1);
      bus.fwd_wb_ad   = pick_ad();
      bus.fwd_wb_data = $urandom;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
